upmix_interp_tx: RTL and testbench
==================================

// Module: upmix_interp_tx
// PURPOSE
// Transmit-side counterpart of the downmixer front-end low-pass filter. Accepts baseband samples
// over a valid/ready handshake and holds each one for INTERP output ticks (zero-order hold).
// Smooths the held stream with a TAPS-point moving average.
// Mixes the result with a quarter-rate LO (+1, 0, -1, 0) at MIXING_FREQ and drives the DAC path.
// PARAMETERS
// DATA_WIDTH   16         sample width, signed two's complement, in and out
// TAPS         8          moving-average length; power of two, >= 2
// INTERP       16         output ticks per input sample
// SYS_CLK_FREQ 6_400_000  clk frequency, Hz
// MIXING_FREQ  320_000    LO frequency, Hz; OUT_DIV = SYS_CLK_FREQ/(4*MIXING_FREQ) = 5 clk per tick
// PORTS
// clk         in   1           system clock
// rst         in   1           asynchronous, active-low reset
// start       in   1           run enable; low = idle/flush
// in_valid    in   1           sample_in is valid
// in_ready    out  1           hold register empty, sample accepted when in_valid&&in_ready
// sample_in   in   DATA_WIDTH  baseband sample, signed
// sample_out  out  DATA_WIDTH  mixed output, signed, registered
// out_valid   out  1           one-clk pulse per output tick
// underrun    out  1           sticky: an input sample was missing at a hold boundary
// BEHAVIOUR
// - Reset (async, rst=0): sample_out=0, out_valid=0, in_ready=1, underrun=0, state=IDLE.
//   All counters, taps, sum, cur and phase are 0; the hold register is emptied.
// - Tick: tick_cnt counts 0..OUT_DIV-1 while state!=IDLE; tick=1 on the clk where tick_cnt==OUT_DIV-1.
// - Hold register: 1 entry; written when in_valid&&in_ready. in_ready=!hold_full in every state.
//   A pop and a write never occur in the same clk.
// - FSM IDLE: counters=0, taps/sum/cur/phase=0, out_valid=0, sample_out holds. start=1 -> PRIME; underrun cleared.
// - FSM PRIME: no underrun flagging, no out_valid. On a tick with hold_full, pop into cur, interp_cnt=0 -> RUN.
// - FSM RUN: on every tick:
//   - taps shift: tap[0]<=cur.
//   - sum <= sum + cur - tap[TAPS-1]; sum is DATA_WIDTH+log2(TAPS) bits, exact, never overflows.
//   - avg = sum >>> log2(TAPS), using the pre-update sum (arithmetic shift, floor).
//   - sample_out <= phase0: avg, 1: 0, 2: -avg, 3: 0. -(-2^(DW-1)) saturates to 2^(DW-1)-1.
//   - out_valid=1 for this clk; phase <= phase+1 (2-bit wrap); interp_cnt <= interp_cnt+1, wraps at INTERP-1.
//   - On a tick with interp_cnt==INTERP-1: pop hold into cur. If hold empty: cur<=0, underrun<=1.
// - Latency: a sample popped into cur appears in sum after 1 tick and in sample_out after 2 ticks.
//   It is fully weighted after TAPS+1 ticks.
// - Leaving RUN/PRIME: start=0 in any state -> IDLE on the next clk. The hold register keeps its content.
//   A restart therefore consumes that sample first. start toggling never changes in_ready.
// TESTING
// 1 Reset mid-RUN: assert rst=0 while out_valid toggling -> same clk: sample_out=0, out_valid=0, in_ready=1, underrun=0.
// 2 Cadence: start=1, in_valid held with 1000 -> out_valid every 5 clk.
//   After 9 ticks, repeating pattern 1000, 0, -1000, 0; underrun stays 0.
// 3 Step: 0 for 32 ticks, then 800 -> avg ramps 100, 200 ... 800 over 8 ticks.
//   Phase-0 samples are +k*100, phase-2 samples are -k*100.
// 4 Underrun: feed 1000 then stop in_valid -> at the next INTERP boundary underrun=1 (sticky).
//   Output magnitude decays to 0 within 9 ticks and in_ready stays 1.
// 5 Saturation: constant -32768 -> phase-0 sample_out=-32768, phase-2 sample_out=32767 (no wrap to -32768).
// 6 start drop/restart: start=0 mid-RUN -> no out_valid from the next clk. On restart, PRIME again.
//   The first out_valid is phase 0 with value 0, and underrun is cleared.

Source files
------------

// File: rtl/upmix_interp_tx.sv
// upmix_interp_tx: zero-order-hold interpolator, moving-average smoother and quarter-rate LO mixer
module upmix_interp_tx #(
  parameter int DATA_WIDTH   = 16,
  parameter int TAPS         = 8,
  parameter int INTERP       = 16,
  parameter int SYS_CLK_FREQ = 6_400_000,
  parameter int MIXING_FREQ  = 320_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  out_valid,
  output logic                  underrun
);
  localparam int OUT_DIV = SYS_CLK_FREQ / (4 * MIXING_FREQ);
  localparam int SH = $clog2(TAPS);
  localparam int SW = DATA_WIDTH + SH;
  localparam int TW = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;
  localparam int IW = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam logic signed [DATA_WIDTH-1:0] MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t                       r_state;
  logic [TW-1:0]                r_tick_cnt;
  logic [IW-1:0]                r_interp_cnt;
  logic [1:0]                   r_phase;
  logic                         r_hold_full;
  logic signed [DATA_WIDTH-1:0] r_hold;
  logic signed [DATA_WIDTH-1:0] r_cur;
  logic signed [DATA_WIDTH-1:0] r_tap [TAPS];
  logic signed [SW-1:0]         r_sum;
  logic                         w_tick;
  logic                         w_boundary;
  logic                         w_push;
  logic                         w_pop;
  logic signed [DATA_WIDTH-1:0] w_avg;
  logic signed [DATA_WIDTH-1:0] w_neg;
  logic signed [DATA_WIDTH-1:0] w_mix;
  assign in_ready   = !r_hold_full;
  assign w_tick     = (r_state != IDLE) && (r_tick_cnt == TW'(OUT_DIV - 1));
  assign w_boundary = r_interp_cnt == IW'(INTERP - 1);
  assign w_push     = in_valid && !r_hold_full;
  assign w_pop      = start && w_tick && r_hold_full &&
                      ((r_state == PRIME) || (r_state == RUN && w_boundary));
  assign w_avg      = DATA_WIDTH'(r_sum >>> SH);
  assign w_neg      = (w_avg == MIN) ? MAX : -w_avg;
  assign w_mix      = (r_phase == 2'd0) ? w_avg : (r_phase == 2'd2) ? w_neg : '0;
  // single-entry input buffer; its content survives start toggling so a restart consumes it first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_full <= 1'b0;
      r_hold      <= '0;
    end else if (w_push) begin
      r_hold_full <= 1'b1;
      r_hold      <= sample_in;
    end else if (w_pop) begin
      r_hold_full <= 1'b0;
    end
  end
  // control FSM with tick divider, hold cadence, moving-average pipeline and LO mixer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_tick_cnt   <= '0;
      r_interp_cnt <= '0;
      r_phase      <= '0;
      r_cur        <= '0;
      r_sum        <= '0;
      r_tap        <= '{default: '0};
      sample_out   <= '0;
      out_valid    <= 1'b0;
      underrun     <= 1'b0;
    end else if (!start || r_state == IDLE) begin
      r_state      <= start ? PRIME : IDLE;
      r_tick_cnt   <= '0;
      r_interp_cnt <= '0;
      r_phase      <= '0;
      r_cur        <= '0;
      r_sum        <= '0;
      r_tap        <= '{default: '0};
      out_valid    <= 1'b0;
      if (start) underrun <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      out_valid  <= (r_state == RUN) && w_tick;
      if (r_state == PRIME && w_tick && r_hold_full) begin
        r_cur        <= r_hold;
        r_interp_cnt <= '0;
        r_state      <= RUN;
      end
      if (r_state == RUN && w_tick) begin
        r_tap[0] <= r_cur;
        for (int i = 1; i < TAPS; i++) r_tap[i] <= r_tap[i-1];
        r_sum        <= r_sum + SW'(r_cur) - SW'(r_tap[TAPS-1]);
        sample_out   <= w_mix;
        r_phase      <= r_phase + 2'd1;
        r_interp_cnt <= w_boundary ? '0 : r_interp_cnt + 1'b1;
        if (w_boundary) begin
          r_cur    <= r_hold_full ? r_hold : '0;
          underrun <= underrun | !r_hold_full;
        end
      end
    end
  end
endmodule

// File: tb/tb_upmix_interp_tx.sv
// tb_upmix_interp_tx: window-average reference model, per-cycle compare and directed scenario checks
module tb_upmix_interp_tx;
  localparam int DIV = 5;
  localparam int HOLD = 16;
  localparam int TAPS = 8;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sample_in;
  logic [15:0] sample_out;
  logic        out_valid;
  logic        underrun;
  int n_pass = 0;
  int n_total = 0;
  int  got[$];
  time got_t[$];
  int  mode, m_clk, m_n, m_cur, m_left;
  int  m_hold[$];
  int  m_hist[$];
  int  e_valid, e_out, e_under, e_ready;
  upmix_interp_tx dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .sample_in(sample_in), .sample_out(sample_out), .out_valid(out_valid), .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
  endtask
  function automatic int floor8(input int s);
    return (s >= 0) ? s / TAPS : -((-s + TAPS - 1) / TAPS);
  endfunction
  function automatic int window_sum();
    int s = 0;
    foreach (m_hist[i]) s += m_hist[i];
    return s;
  endfunction
  function automatic int mix(input int n, input int avg);
    if (n % 4 == 0) return avg;
    if (n % 4 == 2) return (-avg > 32767) ? 32767 : -avg;
    return 0;
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode = 0; m_clk = 0; m_n = 0; m_cur = 0; m_left = 0;
      m_hold.delete(); m_hist.delete();
      e_valid = 0; e_out = 0; e_under = 0; e_ready = 1;
    end else begin
      automatic bit accept = in_valid && m_hold.size() == 0;
      e_valid = 0;
      if (!start) mode = 0;
      else if (mode == 0) begin
        mode = 1; m_clk = 0; m_n = 0; m_cur = 0; e_under = 0; m_hist.delete();
      end else begin
        m_clk++;
        if (m_clk % DIV == 0) begin
          if (mode == 1) begin
            if (m_hold.size() != 0) begin
              m_cur = m_hold.pop_front(); m_left = HOLD; mode = 2;
            end
          end else begin
            e_out = mix(m_n, floor8(window_sum()));
            e_valid = 1;
            m_n++;
            m_hist.push_back(m_cur);
            if (m_hist.size() > TAPS) void'(m_hist.pop_front());
            m_left--;
            if (m_left == 0) begin
              if (m_hold.size() != 0) m_cur = m_hold.pop_front();
              else begin m_cur = 0; e_under = 1; end
              m_left = HOLD;
            end
          end
        end
      end
      if (accept) m_hold.push_back(int'($signed(sample_in)));
      e_ready = (m_hold.size() == 0) ? 1 : 0;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      chk("out_valid", int'(out_valid), e_valid);
      chk("in_ready", int'(in_ready), e_ready);
      chk("underrun", int'(underrun), e_under);
      chk("sample_out", int'($signed(sample_out)), e_out);
    end
  end
  task automatic collect(input int n);
    int budget = n * DIV + 60;
    while (got.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (out_valid) begin
        got.push_back(int'($signed(sample_out)));
        got_t.push_back($time);
      end
    end
    chk("pulse count", got.size(), n);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0; start = 1'b0; in_valid = 1'b0; sample_in = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    got.delete(); got_t.delete();
  endtask
  function automatic int pulse(input int k);
    return (k >= 1 && k <= got.size()) ? got[k-1] : -99999;
  endfunction
  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; sample_in = '0;
    repeat (2) @(negedge clk);
    chk("reset sample_out", int'(sample_out), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset underrun", int'(underrun), 0);
    #1 rst = 1'b1;
    // cadence with a constant 1000 stream
    @(negedge clk);
    in_valid = 1'b1; sample_in = 16'd1000; start = 1'b1;
    collect(12);
    chk("cadence k3", pulse(3), -250);
    chk("cadence k5", pulse(5), 500);
    chk("cadence k9", pulse(9), 1000);
    chk("cadence k10", pulse(10), 0);
    chk("cadence k11", pulse(11), -1000);
    chk("cadence k12", pulse(12), 0);
    chk("cadence gap", (got_t.size() == 12) ? int'(got_t[11] - got_t[10]) : -1, DIV * 10);
    chk("cadence underrun", int'(underrun), 0);
    // asynchronous reset while a pulse is on the output
    chk("mid-run pulse", int'(out_valid), 1);
    #1 rst = 1'b0;
    #1;
    chk("async sample_out", int'(sample_out), 0);
    chk("async out_valid", int'(out_valid), 0);
    chk("async in_ready", int'(in_ready), 1);
    chk("async underrun", int'(underrun), 0);
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    // step from zero to 800
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; sample_in = 16'd0; start = 1'b1;
    collect(5);
    sample_in = 16'd800;
    collect(44);
    chk("step k32", pulse(32), 0);
    chk("step k33", pulse(33), 0);
    chk("step k35", pulse(35), -200);
    chk("step k37", pulse(37), 400);
    chk("step k39", pulse(39), -600);
    chk("step k41", pulse(41), 800);
    chk("step k43", pulse(43), -800);
    // underrun after a single sample
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; sample_in = 16'd1000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("single held", int'(in_ready), 0);
    start = 1'b1;
    collect(15);
    chk("underrun before boundary", int'(underrun), 0);
    collect(16);
    chk("underrun at boundary", int'(underrun), 1);
    chk("underrun in_ready", int'(in_ready), 1);
    collect(26);
    chk("decay k17", pulse(17), 1000);
    chk("decay k19", pulse(19), -750);
    chk("decay k25", pulse(25), 0);
    chk("decay k26", pulse(26), 0);
    // start drop and restart
    @(negedge clk);
    start = 1'b0;
    begin
      int seen = 0;
      repeat (12) begin
        @(negedge clk);
        seen += int'(out_valid);
      end
      chk("idle pulses", seen, 0);
    end
    chk("idle underrun sticky", int'(underrun), 1);
    sample_in = 16'd500; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("restart underrun", int'(underrun), 0);
    got.delete(); got_t.delete();
    collect(3);
    chk("restart k1", pulse(1), 0);
    chk("restart k3", pulse(3), -125);
    // saturation at full-scale negative input
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; sample_in = 16'h8000; start = 1'b1;
    collect(12);
    chk("sat k1", pulse(1), 0);
    chk("sat k3", pulse(3), 8192);
    chk("sat k9", pulse(9), -32768);
    chk("sat k11", pulse(11), 32767);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
